// File: rtl/morse_pkg.sv
// Shared definitions for the Morse blinker: FSM states and symbol timing in units.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [2:0] DOT_U      = 3'd1;
  localparam logic [2:0] DASH_U     = 3'd3;
  localparam logic [2:0] SYM_GAP_U  = 3'd1;
  localparam logic [2:0] WORD_GAP_U = 3'd7;

  // Mark length in units for one symbol bit (0 = dot, 1 = dash).
  function automatic logic [2:0] mark_units(input logic is_dash);
    return is_dash ? DASH_U : DOT_U;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit prescaler: one-cycle tick every UNIT_CYCLES clocks while enabled.
// restart realigns the count so a new state always gets a full first unit.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 12500000,
  parameter int CNT_WIDTH   = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(UNIT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt;

  // Count down from RELOAD; wrap on zero, reload on restart or when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || !enable) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  assign tick = enable && (cnt == '0);

endmodule

// File: rtl/morse_blinker.sv
// Hardware Morse sequencer: blinks a loaded dot/dash pattern in a loop with
// standard unit timing, with shadowed reloads applied only at word boundaries.
module morse_blinker
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12500000,
  parameter int MAX_SYMS    = 8,
  parameter int LEN_WIDTH   = 4,
  parameter int CNT_WIDTH   = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [MAX_SYMS-1:0]  pattern,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic                 stop,
  output logic                 morse_led,
  output logic                 busy,
  output logic                 word_done
);

  localparam int IDX_W = (MAX_SYMS > 1) ? $clog2(MAX_SYMS) : 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_SYMS);
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

  state_t               state, state_next;
  logic [MAX_SYMS-1:0]  act_pattern, act_pattern_next;
  logic [MAX_SYMS-1:0]  shadow_pattern, shadow_pattern_next;
  logic [LEN_WIDTH-1:0] act_len, act_len_next;
  logic [LEN_WIDTH-1:0] shadow_len, shadow_len_next;
  logic [LEN_WIDTH-1:0] idx, idx_next;
  logic [LEN_WIDTH-1:0] len_clamped;
  logic                 pending, pending_next;
  logic [2:0]           unit_cnt, unit_target;
  logic                 tick, expire, restart, cur_dash;

  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
  assign cur_dash    = act_pattern[idx[IDX_W-1:0]];
  assign restart     = (state == IDLE) || (state_next != state);
  assign expire      = tick && (unit_cnt == unit_target - 3'd1);

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (state != IDLE),
    .restart (restart),
    .tick    (tick)
  );

  // Number of unit ticks the current state lasts.
  always_comb begin
    unit_target = DOT_U;
    unique case (state)
      MARK:    unit_target = mark_units(cur_dash);
      SPACE:   unit_target = SYM_GAP_U;
      GAP:     unit_target = WORD_GAP_U;
      default: unit_target = DOT_U;
    endcase
  end

  // Count unit ticks within a state; cleared on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_cnt <= '0;
    end else if (restart) begin
      unit_cnt <= '0;
    end else if (tick) begin
      unit_cnt <= unit_cnt + 3'd1;
    end
  end

  // Next-state and datapath decisions; stop overrides everything, and a load
  // arriving exactly at the word boundary is treated as already pending.
  always_comb begin
    state_next          = state;
    act_pattern_next    = act_pattern;
    act_len_next        = act_len;
    shadow_pattern_next = shadow_pattern;
    shadow_len_next     = shadow_len;
    pending_next        = pending;
    idx_next            = idx;
    word_done           = 1'b0;

    if (stop) begin
      state_next   = IDLE;
      pending_next = 1'b0;
    end else begin
      if (state != IDLE && load) begin
        shadow_pattern_next = pattern;
        shadow_len_next     = len_clamped;
        pending_next        = 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (load && length != '0) begin
            act_pattern_next = pattern;
            act_len_next     = len_clamped;
            idx_next         = '0;
            state_next       = MARK;
          end
        end
        MARK: begin
          if (expire) begin
            state_next = ((idx + ONE) < act_len) ? SPACE : GAP;
          end
        end
        SPACE: begin
          if (expire) begin
            idx_next   = idx + ONE;
            state_next = MARK;
          end
        end
        GAP: begin
          if (expire) begin
            word_done    = 1'b1;
            idx_next     = '0;
            pending_next = 1'b0;
            state_next   = MARK;
            if (load) begin
              if (len_clamped == '0) begin
                state_next = IDLE;
              end else begin
                act_pattern_next = pattern;
                act_len_next     = len_clamped;
              end
            end else if (pending) begin
              if (shadow_len == '0) begin
                state_next = IDLE;
              end else begin
                act_pattern_next = shadow_pattern;
                act_len_next     = shadow_len;
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, pattern registers and registered LED/busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      act_pattern    <= '0;
      act_len        <= '0;
      shadow_pattern <= '0;
      shadow_len     <= '0;
      pending        <= 1'b0;
      idx            <= '0;
      morse_led      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_next;
      act_pattern    <= act_pattern_next;
      act_len        <= act_len_next;
      shadow_pattern <= shadow_pattern_next;
      shadow_len     <= shadow_len_next;
      pending        <= pending_next;
      idx            <= idx_next;
      morse_led      <= (state_next == MARK);
      busy           <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_morse_blinker.sv
// Self-checking bench for morse_blinker: a word-level LED timeline model plus
// directed vectors, hand sequences for corner cases and randomized traffic.
module tb_morse_blinker;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic       stop;
  logic [7:0] pattern;
  logic [3:0] length;
  logic       morse_led;
  logic       busy;
  logic       word_done;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: the remaining LED samples of the current word.
  bit         m_active;
  bit         m_pend;
  bit         m_q[$];
  logic [7:0] m_pat;
  logic [7:0] m_sh_pat;
  int         m_len;
  int         m_sh_len;

  typedef struct {
    string      name;
    bit         ld;
    bit         st;
    logic [7:0] pat;
    logic [3:0] len;
    bit         exp_led;
    bit         exp_busy;
  } vec_t;

  morse_blinker #(
    .UNIT_CYCLES (U),
    .MAX_SYMS    (8),
    .LEN_WIDTH   (4),
    .CNT_WIDTH   (26)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .pattern   (pattern),
    .length    (length),
    .stop      (stop),
    .morse_led (morse_led),
    .busy      (busy),
    .word_done (word_done)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_active = 1'b0;
    m_pend   = 1'b0;
    m_q.delete();
    m_pat    = '0;
    m_sh_pat = '0;
    m_len    = 0;
    m_sh_len = 0;
  endfunction

  // Expand one word into LED samples: marks of 1U/3U, 1U spaces, 7U final gap.
  function automatic void build_word(input logic [7:0] p, input int len);
    m_pat = p;
    m_len = len;
    m_q.delete();
    for (int s = 0; s < len; s++) begin
      int mark_u;
      int space_u;
      mark_u  = p[s] ? 3 : 1;
      space_u = (s == len - 1) ? 7 : 1;
      repeat (mark_u * U) m_q.push_back(1'b1);
      repeat (space_u * U) m_q.push_back(1'b0);
    end
  endfunction

  // Advance the model across one clock edge with the inputs seen at that edge.
  function automatic void model_step(input bit ld, input bit st, input logic [7:0] p, input logic [3:0] n);
    int len;
    len = int'(n);
    if (len > 8) len = 8;
    if (st) begin
      m_active = 1'b0;
      m_pend   = 1'b0;
      m_q.delete();
    end else if (!m_active) begin
      if (ld && len != 0) begin
        build_word(p, len);
        m_active = 1'b1;
      end
    end else if (m_q.size() == 1) begin
      logic [7:0] np;
      int         nl;
      np = m_pat;
      nl = m_len;
      if (ld) begin
        np = p;
        nl = len;
      end else if (m_pend) begin
        np = m_sh_pat;
        nl = m_sh_len;
      end
      m_pend = 1'b0;
      if (nl == 0) begin
        m_active = 1'b0;
        m_q.delete();
      end else begin
        build_word(np, nl);
      end
    end else begin
      void'(m_q.pop_front());
      if (ld) begin
        m_sh_pat = p;
        m_sh_len = len;
        m_pend   = 1'b1;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, check against the model mid-cycle, step the model.
  task automatic applyStimulus(input bit ld, input bit st, input logic [7:0] p, input logic [3:0] n);
    bit exp_led;
    bit exp_wd;
    load    = ld;
    stop    = st;
    pattern = p;
    length  = n;
    @(negedge clk);
    exp_led = m_active ? m_q[0] : 1'b0;
    exp_wd  = m_active && (m_q.size() == 1) && !st;
    checkOutput("led", morse_led, exp_led);
    checkOutput("busy", busy, m_active);
    checkOutput("word_done", word_done, exp_wd);
    @(posedge clk);
    model_step(ld, st, p, n);
    #1;
    load = 1'b0;
    stop = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, 4'h0);
  endtask

  initial begin
    vec_t vecs[6];
    int   hi_cnt;
    int   wd_cnt;

    rst_n   = 1'b0;
    load    = 1'b0;
    stop    = 1'b0;
    pattern = '0;
    length  = '0;
    model_reset();
    #12;
    checkOutput("reset_led", morse_led, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_word_done", word_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors from IDLE: one input cycle, then the outputs that follow.
    vecs[0] = '{"load_a",     1'b1, 1'b0, 8'h02, 4'd2,  1'b1, 1'b1};
    vecs[1] = '{"load_len0",  1'b1, 1'b0, 8'h00, 4'd0,  1'b0, 1'b0};
    vecs[2] = '{"load_stop",  1'b1, 1'b1, 8'h02, 4'd2,  1'b0, 1'b0};
    vecs[3] = '{"stop_idle",  1'b0, 1'b1, 8'h00, 4'd0,  1'b0, 1'b0};
    vecs[4] = '{"load_len12", 1'b1, 1'b0, 8'hFF, 4'd12, 1'b1, 1'b1};
    vecs[5] = '{"load_t",     1'b1, 1'b0, 8'h01, 4'd1,  1'b1, 1'b1};
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ld, vecs[i].st, vecs[i].pat, vecs[i].len);
      checkOutput({vecs[i].name, "_led"}, morse_led, vecs[i].exp_led);
      checkOutput({vecs[i].name, "_busy"}, busy, vecs[i].exp_busy);
      idleCycles(3);
      applyStimulus(1'b0, 1'b1, 8'h00, 4'h0);
    end

    // 'A': one word is 48 clocks with 16 LED-high clocks and one word_done.
    applyStimulus(1'b1, 1'b0, 8'h02, 4'd2);
    hi_cnt = 0;
    wd_cnt = 0;
    for (int j = 0; j < 48; j++) begin
      hi_cnt += int'(morse_led);
      wd_cnt += int'(word_done);
      idleCycles(1);
    end
    checkOutput("a_high_clocks", hi_cnt, 16);
    checkOutput("a_word_done_count", wd_cnt, 1);
    idleCycles(48);
    applyStimulus(1'b0, 1'b1, 8'h00, 4'h0);

    // 'S': three dots looping.
    applyStimulus(1'b1, 1'b0, 8'h00, 4'd3);
    idleCycles(100);
    applyStimulus(1'b0, 1'b1, 8'h00, 4'h0);

    // Reload to 'T' during the first dash of 'A'.
    applyStimulus(1'b1, 1'b0, 8'h02, 4'd2);
    idleCycles(11);
    applyStimulus(1'b1, 1'b0, 8'h01, 4'd1);
    idleCycles(120);
    applyStimulus(1'b0, 1'b1, 8'h00, 4'h0);

    // Load landing exactly on the last gap cycle of 'A'.
    applyStimulus(1'b1, 1'b0, 8'h02, 4'd2);
    idleCycles(47);
    applyStimulus(1'b1, 1'b0, 8'h01, 4'd1);
    idleCycles(45);
    applyStimulus(1'b0, 1'b1, 8'h00, 4'h0);

    // Stop during a dash.
    applyStimulus(1'b1, 1'b0, 8'h02, 4'd2);
    idleCycles(11);
    applyStimulus(1'b0, 1'b1, 8'h00, 4'h0);
    checkOutput("stop_dash_led", morse_led, 1'b0);
    checkOutput("stop_dash_busy", busy, 1'b0);
    idleCycles(5);

    // Pending stop via length 0 while busy: word finishes, then idle.
    applyStimulus(1'b1, 1'b0, 8'h00, 4'd3);
    idleCycles(5);
    applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
    idleCycles(60);
    checkOutput("pending_stop_busy", busy, 1'b0);

    // Length 12 clamps to 8 symbols.
    applyStimulus(1'b1, 1'b0, 8'h00, 4'd12);
    idleCycles(180);
    applyStimulus(1'b0, 1'b1, 8'h00, 4'h0);

    // Async reset in the middle of a dash.
    applyStimulus(1'b1, 1'b0, 8'h02, 4'd2);
    idleCycles(11);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_led", morse_led, 1'b0);
    checkOutput("async_reset_busy", busy, 1'b0);
    checkOutput("async_reset_word_done", word_done, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 8'h00, 4'd3);
    idleCycles(60);
    applyStimulus(1'b0, 1'b1, 8'h00, 4'h0);

    // Randomized loads/stops against the model.
    for (int k = 0; k < 2500; k++) begin
      applyStimulus(($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0),
                    8'($urandom), 4'($urandom_range(0, 12)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/morse_blinker.md
Name: morse_blinker

Overview:
- Hardware Morse sequencer sitting between the CPU bus write and the Morse LED pin, replacing software bit-banging of the LED bit.
- CPU side loads one symbol pattern (dot/dash bits plus length). The block then blinks it with standard unit timing, loops with a word gap until stopped or reloaded, and drives the physical LED.
- Also reports busy and word-complete status for the game logic.

Parameters:
- UNIT_CYCLES, 12500000, clock cycles per Morse time unit (250 ms at 50 MHz).
- MAX_SYMS, 8, maximum symbols per pattern.
- LEN_WIDTH, 4, width of the length field; must satisfy 2^LEN_WIDTH > MAX_SYMS.
- CNT_WIDTH, 26, width of the unit-cycle counter; must hold UNIT_CYCLES-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe: capture pattern/length.
- pattern  in  MAX_SYMS  symbol bits, LSB sent first; 0=dot, 1=dash.
- length  in  LEN_WIDTH  number of valid symbols.
- stop  in  1  one-cycle strobe: abort and go idle.
- morse_led  out  1  LED drive, registered, 1=on.
- busy  out  1  high whenever not IDLE.
- word_done  out  1  one-cycle pulse at end of each word gap.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: morse_led=0, busy=0, word_done=0, state=IDLE. Active pattern, shadow pattern, lengths, symbol index and counters are all 0. Reset mid-blink forces LED off immediately (async).
- Timing in units (U = UNIT_CYCLES clocks):
  - dot mark 1U, dash mark 3U;
  - inter-symbol space 1U;
  - after the last symbol, a word gap of 7U replaces the inter-symbol space (not added to it).
- Length handling: length > MAX_SYMS is clamped to MAX_SYMS at capture. length=0 is a stop request.
- State machine: IDLE, MARK, SPACE, GAP.
  - IDLE: LED 0. load with nonzero length captures into active regs, index=0, goes to MARK. morse_led=1 on the cycle after the load edge (latency 1).
  - MARK: LED 1. Counts 1U or 3U per pattern[index]. At expiry:
    - if index < len-1, go to SPACE;
    - else go to GAP.
  - SPACE: LED 0 for 1U. Then index+1, go to MARK.
  - GAP: LED 0 for 7U. At expiry:
    - word_done pulses 1 cycle;
    - a pending shadow pattern is applied, if any;
    - index=0, go to MARK (loop forever).
- Counter: unit counter counts down from UNIT_CYCLES-1 and ticks on reaching 0. A unit multiplier counter (1/3/7) counts ticks. Durations are exact: a dot is exactly UNIT_CYCLES clocks of LED high.
- load while busy: captured into a shadow register with the pending flag set. It takes effect only at the GAP-to-MARK transition, so the current word is never corrupted. A second load before the boundary overwrites the shadow (last wins).
- load with length=0 while busy: pending stop, applied at the word boundary. The block goes to IDLE instead of MARK and word_done still pulses.
- stop: immediate, from any state, to IDLE. LED 0 next cycle, pending cleared.
- Simultaneous stop and load: stop wins and the load is discarded.
- Simultaneous load and GAP expiry: the new load is applied at this boundary, as if it arrived earlier.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Shared package morse_pkg holds:
  - state encoding enum (IDLE/MARK/SPACE/GAP);
  - unit-multiple constants DOT_U=1, DASH_U=3, SYM_GAP_U=1, WORD_GAP_U=7.
- One sub-module is natural: morse_unit_timer. It is a free-running prescaler that emits a one-cycle tick every UNIT_CYCLES while enabled, and its restart input realigns it on state entry.

Test Plan (UNIT_CYCLES=4):
- 'A': load pattern=0b10, length=2 in IDLE. Expect:
  - LED high exactly 4 clocks starting 1 cycle after load, low 4, high 12, low 28;
  - word_done pulse on the last low cycle;
  - then the pattern repeats; busy=1 throughout.
- 'S': load pattern=0, length=3. Expect high4/low4/high4/low4/high4/low28, repeating. Each word period is 48 clocks.
- Reload mid-word: 'A' running; during its first dash, load 'T' (pattern=1, length=1). Expect:
  - 'A' completes unchanged including the 28-clock gap;
  - next word is high12/low28.
- Stop and clamp:
  - stop during a dash: LED 0 the next cycle, busy 0, no word_done.
  - load length=12: behaves as length=8.
- stop and load asserted the same cycle while idle: block stays IDLE, LED 0.
- Async reset mid-MARK: rst_n low mid-cycle forces LED 0 without a clock edge. After release, the block is IDLE and a fresh load restarts at index 0.
